// File: rtl/serial_demux6_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_demux6_if
// Description : Bundle of the serial-in / word-out signals of serial_demux6.
//               The master drives the serial bit, mode/select/sync and the
//               consumer ready; the slave (the demux) returns the word,
//               its valid, in_ready and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_demux6_if #(
  parameter int LANES  = 6,
  parameter int SEL_W  = 3,
  parameter int DROP_W = 8
);
  logic              in_bit;
  logic              in_valid;
  logic              in_ready;
  logic              sel_mode;
  logic [SEL_W-1:0]  sel;
  logic              sync;
  logic [LANES-1:0]  out_word;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  slot;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output in_bit, in_valid, sel_mode, sel, sync, out_ready,
    input  in_ready, out_word, out_valid, slot, drop_cnt
  );

  modport slave (
    input  in_bit, in_valid, sel_mode, sel, sync, out_ready,
    output in_ready, out_word, out_valid, slot, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/serial_demux6.sv
`default_nettype none
// ============================================================================
// Module      : serial_demux6
// Description : Serial-to-parallel demultiplexer. Each accepted bit is steered
//               into one of LANES lanes, chosen by an internal rotating slot
//               (auto mode) or by an external select (addressed mode). Writing
//               the last lane completes the word, which is presented on a
//               valid/ready output with back-to-back capability.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_demux6 #(
  parameter int LANES  = 6,
  parameter int SEL_W  = 3,
  parameter int DROP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_demux6_if.slave       bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0]  c_last_lane = SEL_W'(LANES - 1);
  localparam logic [DROP_W-1:0] c_drop_max  = {DROP_W{1'b1}};

  state_t              state_q, state_d;
  logic [LANES-1:0]    fill_q, fill_d;
  logic [LANES-1:0]    word_q, word_d;
  logic [SEL_W-1:0]    slot_q, slot_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                in_ready;
  logic                accept;
  logic                complete;
  logic [SEL_W-1:0]    lane;

  assign in_ready      = (state_q == EMPTY) || bus.out_ready;
  assign accept        = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_word  = word_q;
  assign bus.out_valid = (state_q == FULL);
  assign bus.slot      = slot_q;
  assign bus.drop_cnt  = drop_q;

  // Lane decode: sync forces lane 0; addressed selects above the top lane fold onto it.
  always_comb begin
    lane = slot_q;
    if (bus.sync) begin
      lane = '0;
    end else if (bus.sel_mode) begin
      lane = (bus.sel < c_last_lane) ? bus.sel : c_last_lane;
    end
  end

  assign complete = accept && (lane == c_last_lane);

  // Next-state for the fill buffer, slot counter, output word/state and drop counter.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    word_d  = word_q;
    slot_d  = slot_q;
    drop_d  = drop_q;

    // A held word leaves when the consumer takes it; a completion below may refill it.
    if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end

    // sync discards the partial word even when input is being refused.
    if (bus.sync) begin
      fill_d = '0;
      slot_d = '0;
    end

    if (accept) begin
      if (complete) begin
        word_d              = fill_q;
        word_d[LANES-1]     = bus.in_bit;
        state_d             = FULL;
        fill_d              = '0;
        slot_d              = '0;
      end else begin
        for (int i = 0; i < LANES - 1; i++) begin
          if (lane == SEL_W'(i)) begin
            fill_d[i] = bus.in_bit;
          end
        end
        // In auto mode the slot always follows the lane just written (1 after a sync).
        if (!bus.sel_mode) begin
          slot_d = lane + SEL_W'(1);
        end
      end
    end

    if (bus.in_valid && !in_ready && (drop_q != c_drop_max)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // State registers with asynchronous clear of every word, fill and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      fill_q  <= '0;
      word_q  <= '0;
      slot_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      drop_q  <= drop_d;
    end
  end

endmodule
`default_nettype wire
